// File: rtl/multicycle_control_if.sv
// multicycle_control_if: control-unit bus; master = control unit (instr fields/flags in, enables/selects out), slave = datapath
interface multicycle_control_if;
  logic [6:0] instr_op;
  logic [2:0] instr_funct3;
  logic       instr_funct7b5;
  logic       zero;
  logic       lt;
  logic       ltu;
  logic       pc_write;
  logic       ir_write;
  logic       adr_src;
  logic       mem_write;
  logic [2:0] mem_funct3;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_control;
  logic [2:0] imm_src;
  logic       illegal;
  modport master (
    input  instr_op, instr_funct3, instr_funct7b5, zero, lt, ltu,
    output pc_write, ir_write, adr_src, mem_write, mem_funct3, reg_write,
           result_src, alu_src_a, alu_src_b, alu_control, imm_src, illegal
  );
  modport slave (
    output instr_op, instr_funct3, instr_funct7b5, zero, lt, ltu,
    input  pc_write, ir_write, adr_src, mem_write, mem_funct3, reg_write,
           result_src, alu_src_a, alu_src_b, alu_control, imm_src, illegal
  );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: RV32I multicycle control FSM; ports clk, reset (async active-low), bus (master side of multicycle_control_if)
module multicycle_control (
  input logic clk,
  input logic reset,
  multicycle_control_if.master bus
);
  typedef enum logic [3:0] {
    FETCH, IRLOAD, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, JALR2
  } state_t;
  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
    OP_I = 7'b0010011, OP_LUI = 7'b0110111, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
    OP_JALR = 7'b1100111, OP_AUIPC = 7'b0010111, OP_FENCE = 7'b0001111;
  state_t state, state_next;
  logic [6:0] op;
  logic [2:0] f3;
  logic alt, taken, legal;
  logic [3:0] alu_dec;
  assign op = bus.instr_op;
  assign f3 = bus.instr_funct3;
  assign legal = op inside {OP_LOAD, OP_STORE, OP_R, OP_I, OP_LUI, OP_BR, OP_JAL, OP_JALR, OP_AUIPC, OP_FENCE};
  // funct7b5 picks sub only for register ops; it picks sra for both shift forms
  assign alt = bus.instr_funct7b5 & (state == EXECR | f3 == 3'b101);
  assign taken = f3[2:1] == 2'b00 ? bus.zero ^ f3[0] :
                 f3[2:1] == 2'b10 ? bus.lt ^ f3[0] :
                 f3[2:1] == 2'b11 ? bus.ltu ^ f3[0] : 1'b0;
  assign bus.imm_src = op inside {OP_LOAD, OP_I, OP_JALR} ? 3'b000 :
                       op == OP_STORE ? 3'b001 :
                       op == OP_BR ? 3'b010 :
                       op == OP_JAL ? 3'b011 :
                       op inside {OP_LUI, OP_AUIPC} ? 3'b100 : 3'b000;
  always_comb begin
    case (f3)
      3'b000:  alu_dec = alt ? 4'd1 : 4'd0;
      3'b001:  alu_dec = 4'd2;
      3'b010:  alu_dec = 4'd3;
      3'b011:  alu_dec = 4'd4;
      3'b100:  alu_dec = 4'd5;
      3'b101:  alu_dec = alt ? 4'd7 : 4'd6;
      3'b110:  alu_dec = 4'd8;
      default: alu_dec = 4'd9;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= FETCH;
    else state <= state_next;
  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH:   state_next = IRLOAD;
      IRLOAD:  state_next = DECODE;
      DECODE:
        case (op)
          OP_LOAD, OP_STORE: state_next = MEMADR;
          OP_R:              state_next = EXECR;
          OP_I, OP_LUI:      state_next = EXECI;
          OP_BR:             state_next = BRANCH;
          OP_JAL:            state_next = JAL;
          OP_JALR:           state_next = JALR;
          OP_AUIPC:          state_next = ALUWB;
          default:           state_next = FETCH;
        endcase
      MEMADR:  state_next = op == OP_LOAD ? MEMREAD : MEMWRITE;
      MEMREAD: state_next = MEMWB;
      EXECR, EXECI, JAL, JALR2: state_next = ALUWB;
      JALR:    state_next = JALR2;
      default: state_next = FETCH;
    endcase
  end
  always_comb begin
    bus.pc_write = 1'b0;
    bus.ir_write = 1'b0;
    bus.adr_src = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_funct3 = 3'b010;
    bus.reg_write = 1'b0;
    bus.result_src = 2'b00;
    bus.alu_src_a = 2'b00;
    bus.alu_src_b = 2'b00;
    bus.alu_control = 4'd0;
    bus.illegal = 1'b0;
    case (state)
      IRLOAD: begin
        bus.ir_write = 1'b1;
        bus.pc_write = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.result_src = 2'b10;
      end
      DECODE: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b01;
        bus.illegal = !legal;
      end
      MEMADR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
      end
      MEMREAD: begin
        bus.adr_src = 1'b1;
        bus.mem_funct3 = f3;
      end
      MEMWB: begin
        bus.reg_write = 1'b1;
        bus.result_src = 2'b01;
      end
      MEMWRITE: begin
        bus.adr_src = 1'b1;
        bus.mem_write = 1'b1;
        bus.mem_funct3 = f3;
      end
      EXECR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_control = alu_dec;
      end
      EXECI: begin
        bus.alu_src_a = op == OP_LUI ? 2'b11 : 2'b10;
        bus.alu_src_b = 2'b01;
        bus.alu_control = op == OP_LUI ? 4'd0 : alu_dec;
      end
      ALUWB: bus.reg_write = 1'b1;
      BRANCH: begin
        bus.alu_src_a = 2'b10;
        bus.alu_control = 4'd1;
        bus.pc_write = taken;
      end
      JAL, JALR2: begin
        bus.pc_write = 1'b1;
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
      end
      JALR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
      end
      default: ;
    endcase
  end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Control unit for the multicycle RV32I core: a Moore/Mealy state machine that sequences each instruction through fetch, decode, execute, memory and writeback. It drives every datapath enable and mux select around `program_counter`, `register_file`, `immediate_extension`, the ALU and the `memory` block. It consumes the opcode fields of the instruction register and the ALU flags.

## Interface
No parameters.
- `clk`  in  1  system clock; all state changes on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `instr_op`  in  7  instruction register bits [6:0].
- `instr_funct3`  in  3  instruction register bits [14:12].
- `instr_funct7b5`  in  1  instruction register bit 30.
- `zero`, `lt`, `ltu`  in  1 each  ALU flags for the current compare: equal, signed less-than, unsigned less-than.
- `pc_write`  out  1  load PC from the result bus; the datapath clears bit 0.
- `ir_write`  out  1  load the IR from `imem_data_out` and load old_pc from PC.
- `adr_src`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `mem_write`  out  1  dmem write enable.
- `mem_funct3`  out  3  access size to `memory`.
- `reg_write`  out  1  register file write enable.
- `result_src`  out  2  result bus select: 00 = ALUOut, 01 = dmem_data_out, 10 = ALU result direct.
- `alu_src_a`  out  2  00 = PC, 01 = old_pc, 10 = rs1 register A, 11 = zero.
- `alu_src_b`  out  2  00 = rs2 register B, 01 = imm_ext, 10 = constant 4.
- `alu_control`  out  4  ALU operation: 0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and.
- `imm_src`  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U. `immediate_extension` is widened to accept U.
- `illegal`  out  1  one-cycle pulse on an unsupported opcode.

## Operation
- **imm_src**: combinational from `instr_op` in every state.
  - load, OP-IMM, jalr → I
  - store → S
  - branch → B
  - jal → J
  - lui, auipc → U
  - otherwise → 000
- **Output defaults in every state unless listed below**: all enables 0, adr_src 0, result_src 00, alu_src_a 00, alu_src_b 00, alu_control add, mem_funct3 010.
- **FETCH**: adr_src 0, so the PC is presented to memory. Next state IRLOAD.
- **IRLOAD**: ir_write 1, pc_write 1, PC+4 computed as alu_src_a 00, alu_src_b 10, result_src 10. Next state DECODE.
- **DECODE**: computes old_pc+imm into ALUOut (alu_src_a 01, alu_src_b 01). Dispatch on op:
  - 0000011 / 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011, 0110111 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0010111 (auipc) → ALUWB
  - 0001111 (fence) → FETCH
  - any other op, including 1110011 → FETCH with illegal 1
- **MEMADR**: computes A+imm. Next state MEMREAD for a load, MEMWRITE for a store.
- **MEMREAD**: adr_src 1, mem_funct3 = instr_funct3. Next state MEMWB.
- **MEMWB**: reg_write 1, result_src 01. Next state FETCH.
- **MEMWRITE**: adr_src 1, mem_write 1, mem_funct3 = instr_funct3. Next state FETCH.
- **EXECR**: alu_src_a 10, alu_src_b 00. alu_control decoded from funct3; funct7b5 selects sub or sra. Next state ALUWB.
- **EXECI**: alu_src_a 10, alu_src_b 01. funct7b5 is used only for srai; addi never maps to sub. For lui: alu_src_a 11, add. Next state ALUWB.
- **ALUWB**: reg_write 1, result_src 00. Next state FETCH.
- **BRANCH**: alu_src_a 10, alu_src_b 00, alu_control sub. Next state FETCH.
  - Taken condition by funct3: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu.
  - pc_write = taken, with result_src 00. This is the only Mealy output.
  - funct3 010 or 011 → not taken.
- **JAL**: pc_write 1, result_src 00, and old_pc+4 computed into ALUOut. Next state ALUWB.
- **JALR**: A+imm computed into ALUOut. Next state JALR2.
- **JALR2**: pc_write 1, result_src 00, and old_pc+4 computed into ALUOut. Next state ALUWB.
- **State encoding**: 4 bits, FETCH = 0.

## Timing
- **Reset**: reset low forces state FETCH asynchronously. While reset is low, pc_write, ir_write, mem_write, reg_write and illegal are forced to 0. All other outputs take their FETCH values.
- **Reset deassertion**: the first posedge after reset goes high moves FETCH → IRLOAD.
- **Reset mid-instruction**: the instruction is abandoned with no partial write.
- **Memory**: read is synchronous, so data addressed in FETCH/MEMREAD is valid in IRLOAD/MEMWB.
- **Cycles per instruction**:

  | Class | Cycles |
  |---|---|
  | branch | 4 |
  | auipc | 4 |
  | fence | 3 |
  | illegal | 3 |
  | R-type | 5 |
  | OP-IMM | 5 |
  | lui | 5 |
  | store | 5 |
  | jal | 5 |
  | load | 6 |
  | jalr | 6 |

- **Write enables**: each is high for at most one cycle per instruction, except pc_write, which is high in IRLOAD and again in the jump/branch state.

## Test plan
- Reset low mid-EXECR, then release → outputs at FETCH defaults immediately. Next edges show IRLOAD with ir_write=1, pc_write=1.
- op 0110011, funct3 000, funct7b5 1 (sub) → state sequence 0, IRLOAD, DECODE, EXECR (alu_control 1), ALUWB (reg_write 1), 0. Total 5 cycles.
- lw (op 0000011, funct3 010) then sb (op 0100011, funct3 000):
  - lw → MEMREAD with adr_src 1, mem_funct3 010; MEMWB with result_src 01, reg_write 1.
  - sb → mem_write 1 for exactly one cycle with mem_funct3 000.
- bne (funct3 001):
  - zero=1 → no pc_write in BRANCH.
  - zero=0 → pc_write 1, result_src 00.
  - bltu with ltu=1 → taken.
  - funct3 010 → never taken.
- jalr → pc_write in JALR2, reg_write in ALUWB, 6 cycles total. auipc → ALUWB directly after DECODE, 4 cycles.
- op 1110011 → illegal=1 for one cycle in DECODE, no write enables asserted, returns to FETCH.
